// File: rtl/multicycle_ctrl_fsm_if.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl_fsm_if
//   Shared instruction/data memory port between the multi-cycle control unit
//   and the memory subsystem. The controller is the master and issues the
//   request. The memory is the slave and reports completion.
//
//   mem_req    master->slave  request pending (instruction fetch or data access)
//   mem_we     master->slave  write strobe, only for stores
//   i_fetch    master->slave  request is an instruction fetch (address from PC)
//   mem_ready  slave->master  memory completes the current request this cycle
// ----------------------------------------------------------------------------
interface multicycle_ctrl_fsm_if;
  logic mem_req;
  logic mem_we;
  logic i_fetch;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output i_fetch, input mem_ready);
  modport slave  (input mem_req, input mem_we, input i_fetch, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl_fsm
//   Multi-cycle RV32I control unit. Each instruction is sequenced through
//   FETCH / DECODE / EXEC / (MEM) / (WB). opcode, funct3 and funct7 are latched
//   once in DECODE. Every ALU and datapath control from EXEC onward comes from
//   that latch. A memory access that waits too long for mem_ready, an illegal
//   opcode, or a SYSTEM instruction parks the unit in TRAP or HALT until reset.
//
// Ports
//   clk, rst_n  clock (rising edge) and asynchronous active-low reset
//   bus         shared memory port (mem_req, mem_we, i_fetch / mem_ready)
//   inst        instruction register contents, valid from DECODE onward
//   br_taken    branch compare result. The datapath combines it with Branch.
//   IRWrite     load the instruction register (FETCH, on mem_ready)
//   PCWrite     update the PC (branch in EXEC, store completion, WB)
//   ALUOp       ALU operation code, zero-extended to ALUOP_W
//   ALUSrc      ALU operand B select: 0 rs2, 1 imm, 2 PC+imm
//   Branch      B / JAL / JALR class (next-PC select)
//   MemtoReg    writeback from memory (loads)
//   RegWrite    register-file write enable (WB)
//   halted      sticky: a SYSTEM instruction retired
//   trap        sticky: illegal opcode or bus timeout
//   bus_err     sticky: the trap was caused by a bus timeout
//   state       current state, for debug
// ----------------------------------------------------------------------------
module multicycle_ctrl_fsm #(
  parameter int ALUOP_W    = 4,
  parameter int TIMEOUT    = 16,
  parameter bit ENABLE_SYS = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  multicycle_ctrl_fsm_if.master  bus,
  input  logic [31:0]            inst,
  input  logic                   br_taken,
  output logic                   IRWrite,
  output logic                   PCWrite,
  output logic [ALUOP_W-1:0]     ALUOp,
  output logic [1:0]             ALUSrc,
  output logic                   Branch,
  output logic                   MemtoReg,
  output logic                   RegWrite,
  output logic                   halted,
  output logic                   trap,
  output logic                   bus_err,
  output logic [2:0]             state
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_L     = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  // The counter never has to hold more than TIMEOUT-1.
  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
    S_MEM  = 3'd4, S_WB    = 3'd5, S_HALT   = 3'd6, S_TRAP = 3'd7
  } state_t;

  typedef struct packed {
    logic [6:0] f7;
    logic [2:0] f3;
    logic [6:0] op;
  } dec_t;

  state_t           state_q, state_d;
  dec_t             dec_q;
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_hit;

  // Only opcode/funct fields steer control. The register indices and the
  // branch result are used by the datapath and are collected here on purpose.
  logic unused;
  assign unused = ^{inst[24:15], inst[11:7], br_taken};

  // The last permitted wait cycle has passed without ready. A ready that
  // arrives on that same cycle takes priority.
  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1)) && !bus.mem_ready;

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so that every flop
    // samples values from before the edge, regardless of process order.
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Per-instruction bookkeeping: decode latch, wait counter, timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the decode latch is reset even though it is written before its
      // first use. This keeps the state after reset fully defined and equal to zero.
      dec_q    <= '0;
      wait_cnt <= '0;
      bus_err  <= 1'b0;
    end else begin
      if (state_q == S_DECODE) dec_q <= '{f7: inst[31:25], f3: inst[14:12], op: inst[6:0]};
      // Clearing on every state change makes each FETCH/MEM visit start at 0.
      if (state_d != state_q)                 wait_cnt <= '0;
      else if (bus.mem_req && !bus.mem_ready) wait_cnt <= wait_cnt + CNT_W'(1);
      if ((state_q == S_FETCH || state_q == S_MEM) && timeout_hit) bus_err <= 1'b1;
    end
  end

  // ------------------------------------------------------- latched decode
  logic       cls_r, cls_i, cls_l, cls_s, cls_b, cls_j, cls_jr, cls_lui, cls_auipc;
  logic [3:0] alu_code;
  logic [1:0] alu_src;

  always_comb begin
    cls_r     = (dec_q.op == OP_R);
    cls_i     = (dec_q.op == OP_I);
    cls_l     = (dec_q.op == OP_L);
    cls_s     = (dec_q.op == OP_S);
    cls_b     = (dec_q.op == OP_B);
    cls_j     = (dec_q.op == OP_JAL);
    cls_jr    = (dec_q.op == OP_JALR);
    cls_lui   = (dec_q.op == OP_LUI);
    cls_auipc = (dec_q.op == OP_AUIPC);

    alu_code = 4'd0;
    if (cls_b) begin
      case (dec_q.f3)
        3'd0: alu_code = 4'd8;
        3'd1: alu_code = 4'd9;
        3'd4: alu_code = 4'd10;
        3'd5: alu_code = 4'd11;
        3'd6: alu_code = 4'd12;
        3'd7: alu_code = 4'd13;
        default: alu_code = 4'd0;
      endcase
    end else if (cls_r || cls_i) begin
      case (dec_q.f3)
        // Only R-type uses funct7 to select SUB. For addi those bits are immediate bits.
        3'd0: alu_code = (cls_r && dec_q.f7 == 7'h20) ? 4'd1 : 4'd0;
        3'd1: alu_code = 4'd2;
        3'd2: alu_code = 4'd10;
        3'd3: alu_code = 4'd12;
        3'd4: alu_code = 4'd5;
        3'd5: alu_code = (dec_q.f7 == 7'h20) ? 4'd4 : 4'd3;
        3'd6: alu_code = 4'd6;
        default: alu_code = 4'd7;
      endcase
    end

    alu_src = 2'd0;
    if (cls_i || cls_l || cls_s || cls_lui) alu_src = 2'd1;
    else if (cls_auipc)                     alu_src = 2'd2;
  end

  // ------------------------------------------------------------ next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: begin
        if (bus.mem_ready)    state_d = S_DECODE;
        else if (timeout_hit) state_d = S_TRAP;
      end
      S_DECODE: begin
        case (inst[6:0])
          OP_R, OP_I, OP_L, OP_S, OP_B, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: state_d = S_EXEC;
          OP_SYS:  state_d = ENABLE_SYS ? S_HALT : S_TRAP;
          default: state_d = S_TRAP;
        endcase
      end
      S_EXEC: begin
        if (cls_l || cls_s) state_d = S_MEM;
        else if (cls_b)     state_d = S_FETCH;
        else                state_d = S_WB;
      end
      S_MEM: begin
        if (bus.mem_ready)    state_d = cls_l ? S_WB : S_FETCH;
        else if (timeout_hit) state_d = S_TRAP;
      end
      S_WB:    state_d = S_FETCH;
      default: state_d = state_q;  // HALT and TRAP hold until reset
    endcase
  end

  // --------------------------------------------------------------- outputs
  logic drive_ctl;

  always_comb begin
    // NOTE: every output gets a default first. No path through the case can
    // leave one unassigned, so no latch is inferred.
    bus.mem_req = 1'b0;
    bus.mem_we  = 1'b0;
    bus.i_fetch = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    RegWrite    = 1'b0;
    halted      = 1'b0;
    trap        = 1'b0;
    drive_ctl   = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.mem_req = 1'b1;
        bus.i_fetch = 1'b1;
        IRWrite     = bus.mem_ready;
      end
      S_EXEC: begin
        drive_ctl = 1'b1;
        PCWrite   = cls_b;  // taken or not, the datapath picks target vs PC+4
      end
      S_MEM: begin
        drive_ctl   = 1'b1;
        bus.mem_req = 1'b1;
        bus.mem_we  = cls_s;
        PCWrite     = cls_s && bus.mem_ready;  // a store retires here
      end
      S_WB: begin
        drive_ctl = 1'b1;
        RegWrite  = 1'b1;
        PCWrite   = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      S_TRAP:  trap   = 1'b1;
      default: ;
    endcase
    // ALU and mux controls stay stable from EXEC through MEM/WB.
    ALUOp    = drive_ctl ? ALUOP_W'(alu_code) : '0;
    ALUSrc   = drive_ctl ? alu_src : 2'd0;
    Branch   = drive_ctl && (cls_b || cls_j || cls_jr);
    MemtoReg = drive_ctl && cls_l;
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
module tb_multicycle_ctrl_fsm;

  localparam int ALUOP_W = 5;  // wider than 4 to exercise zero-extension
  localparam int TO      = 8;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_L = 7'b0000011;
  localparam logic [6:0] OP_S = 7'b0100011, OP_B = 7'b1100011, OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_SYS = 7'b1110011;

  localparam logic [6:0] LEGAL_OPS [9] = '{OP_R, OP_I, OP_L, OP_S, OP_B, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
  // ALU code by funct3: R/I arithmetic base table and branch table.
  localparam logic [3:0] RTAB [8] = '{4'd0, 4'd2, 4'd10, 4'd12, 4'd5, 4'd3, 4'd6, 4'd7};
  localparam logic [3:0] BTAB [8] = '{4'd8, 4'd9, 4'd0, 4'd0, 4'd10, 4'd11, 4'd12, 4'd13};

  typedef struct packed {
    logic [2:0]         st;
    logic               req, we, ifetch, irw, pcw;
    logic [ALUOP_W-1:0] aluop;
    logic [1:0]         alusrc;
    logic               br, m2r, rw, hlt, trp, berr;
  } obs_t;

  typedef struct packed {
    obs_t o;
    logic rdy;
  } step_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               br_taken = 1'b0;
  logic [31:0]        inst = '0;
  logic               IRWrite, PCWrite, Branch, MemtoReg, RegWrite, halted, trap, bus_err;
  logic [ALUOP_W-1:0] ALUOp;
  logic [1:0]         ALUSrc;
  logic [2:0]         state;

  multicycle_ctrl_fsm_if bus ();

  multicycle_ctrl_fsm #(.ALUOP_W(ALUOP_W), .TIMEOUT(TO), .ENABLE_SYS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .inst(inst), .br_taken(br_taken),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .ALUOp(ALUOp), .ALUSrc(ALUSrc),
    .Branch(Branch), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .halted(halted),
    .trap(trap), .bus_err(bus_err), .state(state)
  );

  always #5 clk = ~clk;

  int    n_pass = 0;
  int    n_total = 0;
  step_t exp_q[$];
  obs_t  act_q[$];

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got %0d checks, required completion", n_total);
    $fatal(1, "watchdog expired");
  end

  function automatic obs_t sample();
    obs_t s;
    s.st = state; s.req = bus.mem_req; s.we = bus.mem_we; s.ifetch = bus.i_fetch;
    s.irw = IRWrite; s.pcw = PCWrite; s.aluop = ALUOp; s.alusrc = ALUSrc;
    s.br = Branch; s.m2r = MemtoReg; s.rw = RegWrite; s.hlt = halted;
    s.trp = trap; s.berr = bus_err;
    return s;
  endfunction

  // ----------------------------------------------------- reference model
  function automatic logic [ALUOP_W-1:0] model_aluop(input logic [31:0] ins);
    logic [3:0] code;
    code = 4'd0;
    if (ins[6:0] == OP_B) code = BTAB[ins[14:12]];
    else if (ins[6:0] == OP_R || ins[6:0] == OP_I) begin
      code = RTAB[ins[14:12]];
      if (ins[14:12] == 3'd0 && ins[6:0] == OP_R && ins[31:25] == 7'h20) code = 4'd1;
      if (ins[14:12] == 3'd5 && ins[31:25] == 7'h20) code = 4'd4;
    end
    return ALUOP_W'(code);
  endfunction

  task automatic push_step(input obs_t o, input logic r);
    step_t s;
    s.o = o; s.rdy = r;
    exp_q.push_back(s);
  endtask

  task automatic push_end(input logic [2:0] st, input logic berr);
    obs_t o;
    for (int k = 0; k < 3; k++) begin
      o = '0; o.st = st; o.hlt = (st == 3'd6); o.trp = (st == 3'd7); o.berr = berr;
      push_step(o, 1'($urandom_range(0, 1)));
    end
  endtask

  // Expected per-cycle trace of one instruction, starting in FETCH.
  // fd/md: wait cycles before ready in FETCH/MEM; >= TO means never ready.
  task automatic build(input logic [31:0] ins, input int fd, input int md);
    logic [6:0] op;
    logic       is_l, is_s, is_b, legal;
    obs_t       o, h;
    op = ins[6:0];
    is_l = (op == OP_L); is_s = (op == OP_S); is_b = (op == OP_B);
    legal = 1'b0;
    for (int k = 0; k < 9; k++) if (LEGAL_OPS[k] == op) legal = 1'b1;
    for (int k = 0; k <= fd && k < TO; k++) begin
      o = '0; o.st = 3'd1; o.req = 1'b1; o.ifetch = 1'b1; o.irw = (k == fd);
      push_step(o, k == fd);
    end
    if (fd >= TO) begin push_end(3'd7, 1'b1); return; end
    o = '0; o.st = 3'd2;
    push_step(o, 1'($urandom_range(0, 1)));
    if (op == OP_SYS) begin push_end(3'd6, 1'b0); return; end
    if (!legal)       begin push_end(3'd7, 1'b0); return; end
    h = '0;
    h.aluop  = model_aluop(ins);
    h.alusrc = (op == OP_AUIPC) ? 2'd2 :
               (op == OP_I || is_l || is_s || op == OP_LUI) ? 2'd1 : 2'd0;
    h.br     = is_b || op == OP_JAL || op == OP_JALR;
    h.m2r    = is_l;
    o = h; o.st = 3'd3; o.pcw = is_b;
    push_step(o, 1'($urandom_range(0, 1)));
    if (is_b) return;
    if (is_l || is_s) begin
      for (int k = 0; k <= md && k < TO; k++) begin
        o = h; o.st = 3'd4; o.req = 1'b1; o.we = is_s; o.pcw = is_s && (k == md);
        push_step(o, k == md);
      end
      if (md >= TO) begin push_end(3'd7, 1'b1); return; end
      if (is_s) return;
    end
    o = h; o.st = 3'd5; o.rw = 1'b1; o.pcw = 1'b1;
    push_step(o, 1'($urandom_range(0, 1)));
  endtask

  // Plays exp_q's input side (bt: 0/1 fixed br_taken, 2 random), records outputs.
  task automatic run(input int bt);
    foreach (exp_q[i]) begin
      @(negedge clk);
      bus.mem_ready = exp_q[i].rdy;
      br_taken = (bt == 2) ? 1'($urandom_range(0, 1)) : 1'(bt);
      #1;
      act_q.push_back(sample());
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ------------------------------------------------------------ scenarios
  task automatic test_reset();
    obs_t got;
    bus.mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    got = sample();
    n_total++;
    if (got !== '0) $display("FAIL reset_held: got %h required %h", got, obs_t'('0));
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    got = sample();
    n_total++;
    if (got !== '0) $display("FAIL reset_idle: got %h required %h", got, obs_t'('0));
    else n_pass++;
  endtask

  task automatic test_add();
    exp_q.delete(); act_q.delete();
    inst = 32'h002081B3;
    build(inst, 0, 0);
    run(2);
    foreach (exp_q[i]) begin
      n_total++;
      if (act_q[i] !== exp_q[i].o) $display("FAIL add cyc %0d: got %h required %h", i, act_q[i], exp_q[i].o);
      else n_pass++;
    end
  endtask

  task automatic test_load();
    exp_q.delete(); act_q.delete();
    inst = 32'h0000A283;
    build(inst, 0, 3);
    run(2);
    foreach (exp_q[i]) begin
      n_total++;
      if (act_q[i] !== exp_q[i].o) $display("FAIL lw cyc %0d: got %h required %h", i, act_q[i], exp_q[i].o);
      else n_pass++;
    end
  endtask

  task automatic test_store();
    exp_q.delete(); act_q.delete();
    inst = 32'h0050A223;
    build(inst, 1, 2);
    run(2);
    foreach (exp_q[i]) begin
      n_total++;
      if (act_q[i] !== exp_q[i].o) $display("FAIL sw cyc %0d: got %h required %h", i, act_q[i], exp_q[i].o);
      else n_pass++;
    end
  endtask

  task automatic test_branch();
    exp_q.delete(); act_q.delete();
    inst = 32'h00000063;
    build(inst, 0, 0);
    run(1);
    foreach (exp_q[i]) begin
      n_total++;
      if (act_q[i] !== exp_q[i].o) $display("FAIL beq cyc %0d: got %h required %h", i, act_q[i], exp_q[i].o);
      else n_pass++;
    end
  endtask

  // Ready on the very last permitted wait cycle, in FETCH and in MEM.
  task automatic test_ready_boundary();
    exp_q.delete(); act_q.delete();
    inst = 32'h0000A283;
    build(inst, TO - 1, TO - 1);
    run(2);
    foreach (exp_q[i]) begin
      n_total++;
      if (act_q[i] !== exp_q[i].o) $display("FAIL ready_edge cyc %0d: got %h required %h", i, act_q[i], exp_q[i].o);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [31:0] ins;
    for (int n = 0; n < 60; n++) begin
      exp_q.delete(); act_q.delete();
      ins = $urandom;
      ins[6:0] = LEGAL_OPS[$urandom_range(0, 8)];
      case ($urandom_range(0, 2))
        0: ins[31:25] = 7'h00;
        1: ins[31:25] = 7'h20;
        default: ;
      endcase
      inst = ins;
      build(ins, ($urandom_range(0, 7) == 0) ? TO - 1 : int'($urandom_range(0, 3)),
                 ($urandom_range(0, 7) == 0) ? TO - 1 : int'($urandom_range(0, 3)));
      run(2);
      foreach (exp_q[i]) begin
        n_total++;
        if (act_q[i] !== exp_q[i].o)
          $display("FAIL rand inst %h cyc %0d: got %h required %h", ins, i, act_q[i], exp_q[i].o);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid_wb();
    obs_t got;
    exp_q.delete(); act_q.delete();
    inst = 32'h002081B3;
    build(inst, 0, 0);
    run(2);
    foreach (exp_q[i]) begin
      n_total++;
      if (act_q[i] !== exp_q[i].o) $display("FAIL pre_rst cyc %0d: got %h required %h", i, act_q[i], exp_q[i].o);
      else n_pass++;
    end
    // Currently in WB, with RegWrite/PCWrite high. Reset must clear them at once.
    rst_n = 1'b0;
    #1;
    got = sample();
    n_total++;
    if (got !== '0) $display("FAIL rst_mid_wb: got %h required %h", got, obs_t'('0));
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    got = sample();
    n_total++;
    if (got !== '0) $display("FAIL rst_idle_after_wb: got %h required %h", got, obs_t'('0));
    else n_pass++;
  endtask

  task automatic test_halt();
    exp_q.delete(); act_q.delete();
    inst = 32'h00000073;
    build(inst, 1, 0);
    run(2);
    foreach (exp_q[i]) begin
      n_total++;
      if (act_q[i] !== exp_q[i].o) $display("FAIL halt cyc %0d: got %h required %h", i, act_q[i], exp_q[i].o);
      else n_pass++;
    end
    do_reset();
  endtask

  task automatic test_illegal();
    exp_q.delete(); act_q.delete();
    inst = 32'hFFFFFFFF;
    build(inst, 0, 0);
    run(2);
    foreach (exp_q[i]) begin
      n_total++;
      if (act_q[i] !== exp_q[i].o) $display("FAIL illegal cyc %0d: got %h required %h", i, act_q[i], exp_q[i].o);
      else n_pass++;
    end
    do_reset();
  endtask

  task automatic test_fetch_timeout();
    exp_q.delete(); act_q.delete();
    inst = 32'h002081B3;
    build(inst, TO, 0);
    run(2);
    foreach (exp_q[i]) begin
      n_total++;
      if (act_q[i] !== exp_q[i].o) $display("FAIL fetch_to cyc %0d: got %h required %h", i, act_q[i], exp_q[i].o);
      else n_pass++;
    end
    do_reset();
  endtask

  task automatic test_mem_timeout();
    exp_q.delete(); act_q.delete();
    inst = 32'h0000A283;
    build(inst, 0, TO);
    run(2);
    foreach (exp_q[i]) begin
      n_total++;
      if (act_q[i] !== exp_q[i].o) $display("FAIL mem_to cyc %0d: got %h required %h", i, act_q[i], exp_q[i].o);
      else n_pass++;
    end
  endtask

  initial begin
    bus.mem_ready = 1'b0;
    test_reset();
    test_add();
    test_load();
    test_store();
    test_branch();
    test_ready_boundary();
    test_random();
    test_reset_mid_wb();
    test_halt();
    test_illegal();
    test_fetch_timeout();
    test_mem_timeout();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
